dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (CPU MEM stage, lw/sw)
//  and port 1 (test loader / debug DMA). Issues one word access at a time, checks

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// (port 0) and the test loader / debug DMA (port 1). One word access at a time,
// with alignment/range checking and registered read data plus a valid pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break instead of
// fixed port-0 priority).
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_err_o,
  output logic              p0_rvalid_o,
  output logic [31:0]       p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_err_o,
  output logic              p1_rvalid_o,
  output logic [31:0]       p1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_data_i,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  logic [1:0]        r_state;
  logic              r_owner;
  logic [1:0]        r_gnt;
  logic [1:0]        r_err;
  logic [1:0]        r_rvalid;
  logic [31:0]       r_p0Rdata;
  logic [31:0]       r_p1Rdata;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memData;
  logic              r_memRead;
  logic              r_memWrite;
  logic              r_busy;

  logic              w_anyReq;
  logic              w_sel;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_err;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_lastGnt;

  // Winner select: on a tie the port not granted last wins; a lone requester always wins
  always_comb begin
    w_sel = 1'b0;
    if (p0_req_i && p1_req_i) w_sel = ~r_lastGnt;
    else                      w_sel = ~p0_req_i;
  end

  // Remember the last granted port; reset value 1 lets port 0 win the first tie
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                             r_lastGnt <= 1'b1;
    else if (r_state == ST_IDLE && w_anyReq) r_lastGnt <= w_sel;
  end
`else
  // Winner select: fixed priority, port 0 always beats port 1
  always_comb begin
    w_sel = ~p0_req_i;
  end
`endif

  // Winner's request fields and the alignment/range check done at selection
  always_comb begin
    w_anyReq = p0_req_i | p1_req_i;
    w_we     = w_sel ? p1_we_i    : p0_we_i;
    w_addr   = w_sel ? p1_addr_i  : p0_addr_i;
    w_wdata  = w_sel ? p1_wdata_i : p0_wdata_i;
    w_err    = (w_addr[1:0] != 2'b00) || (w_addr > LAST_WORD);
  end

  // Access FSM: pulse outputs default low each cycle, set only in the cycle they belong to
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_gnt      <= 2'b00;
      r_err      <= 2'b00;
      r_rvalid   <= 2'b00;
      r_p0Rdata  <= '0;
      r_p1Rdata  <= '0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_gnt      <= 2'b00;
      r_err      <= 2'b00;
      r_rvalid   <= 2'b00;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_state        <= ST_CMD;
            r_busy         <= 1'b1;
            r_owner        <= w_sel;
            r_memAddr      <= w_addr;
            r_memData      <= w_wdata;
            r_gnt[w_sel]   <= 1'b1;
            r_err[w_sel]   <= w_err;
            r_memWrite     <= w_we & ~w_err;
            r_memRead      <= ~w_we & ~w_err;
          end
        end
        ST_CMD: begin
          if (r_memRead) begin
            r_state <= ST_RD;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RD: begin
          r_state           <= ST_IDLE;
          r_busy            <= 1'b0;
          r_rvalid[r_owner] <= 1'b1;
          if (r_owner) r_p1Rdata <= mem_data_i;
          else         r_p0Rdata <= mem_data_i;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p0_gnt_o    = r_gnt[0];
  assign p1_gnt_o    = r_gnt[1];
  assign p0_err_o    = r_err[0];
  assign p1_err_o    = r_err[1];
  assign p0_rvalid_o = r_rvalid[0];
  assign p1_rvalid_o = r_rvalid[1];
  assign p0_rdata_o  = r_p0Rdata;
  assign p1_rdata_o  = r_p1Rdata;
  assign mem_addr_o  = r_memAddr;
  assign mem_data_o  = r_memData;
  assign mem_read_o  = r_memRead;
  assign mem_write_o = r_memWrite;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural Data_Memory,
// a reference memory image and per-port read-data scoreboards.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        p0_req_i = 1'b0, p0_we_i = 1'b0;
  logic [31:0] p0_addr_i = '0, p0_wdata_i = '0;
  logic        p1_req_i = 1'b0, p1_we_i = 1'b0;
  logic [31:0] p1_addr_i = '0, p1_wdata_i = '0;
  logic        p0_gnt_o, p0_err_o, p0_rvalid_o;
  logic [31:0] p0_rdata_o;
  logic        p1_gnt_o, p1_err_o, p1_rvalid_o;
  logic [31:0] p1_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_data_i;
  logic        busy_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] refMem [8];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] holdP0 = '0;
  logic        tbLast = 1'b1;

  logic [31:0] mem [8];
  logic [31:0] memRdata = '0;
  bit          memInit;

  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p0_err_o(p0_err_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_gnt_o(p1_gnt_o), .p1_err_o(p1_err_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_data_i(mem_data_i), .busy_o(busy_o)
  );

  assign mem_data_i = memRdata;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] initWord(input int i);
    return 32'hA5000000 | (32'(i) * 32'h0000_0101);
  endfunction

  // Behavioural Data_Memory: synchronous write, one-cycle registered read
  always @(posedge clk_i) begin
    if (!memInit) begin
      for (int i = 0; i < 8; i++) mem[i] = initWord(i);
      memInit = 1'b1;
    end
    if (mem_read_o)  memRdata = mem[mem_addr_o[4:2]];
    if (mem_write_o) mem[mem_addr_o[4:2]] = mem_data_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read-data scoreboard: every rvalid must match the oldest expected word of that port
  always @(negedge clk_i) begin
    if (p0_rvalid_o) begin
      if (q0.size() == 0) checkOutput("p0_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        holdP0 = q0.pop_front();
        checkOutput("p0_rdata", p0_rdata_o, holdP0);
      end
    end
    if (p1_rvalid_o) begin
      if (q1.size() == 0) checkOutput("p1_rvalid_unexpected", 32'd1, 32'd0);
      else checkOutput("p1_rdata", p1_rdata_o, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic setReq(input int port, input logic we, input logic [31:0] addr, input logic [31:0] data);
    if (port == 0) begin
      p0_req_i = 1'b1; p0_we_i = we; p0_addr_i = addr; p0_wdata_i = data;
    end else begin
      p1_req_i = 1'b1; p1_we_i = we; p1_addr_i = addr; p1_wdata_i = data;
    end
  endtask

  task automatic clearReqs;
    p0_req_i = 1'b0;
    p1_req_i = 1'b0;
  endtask

  // One complete access from request to return-to-idle, checked cycle by cycle
  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic expErr);
    logic isRead;
    logic legal;
    logic [31:0] gntVec;
    legal  = !expErr;
    isRead = !we && legal;
    gntVec = (port == 0) ? 32'd1 : 32'd2;
    setReq(port, we, addr, data);
    step;
    checkOutput("gnt_c1", {30'b0, p1_gnt_o, p0_gnt_o}, gntVec);
    checkOutput("err_c1", {30'b0, p1_err_o, p0_err_o}, expErr ? gntVec : 32'd0);
    checkOutput("mem_write_c1", 32'(mem_write_o), 32'(we && legal));
    checkOutput("mem_read_c1", 32'(mem_read_o), 32'(isRead));
    checkOutput("busy_c1", 32'(busy_o), 32'd1);
    if (legal) checkOutput("mem_addr_c1", mem_addr_o, addr);
    if (we && legal) begin
      checkOutput("mem_data_c1", mem_data_o, data);
      refMem[addr[4:2]] = data;
    end
    if (isRead) begin
      if (port == 0) q0.push_back(refMem[addr[4:2]]);
      else           q1.push_back(refMem[addr[4:2]]);
    end
    tbLast = (port != 0);
    clearReqs();
    step;
    checkOutput("gnt_c2", {30'b0, p1_gnt_o, p0_gnt_o}, 32'd0);
    checkOutput("strobes_c2", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    checkOutput("busy_c2", 32'(busy_o), 32'(isRead));
    if (isRead) begin
      step;
      checkOutput("busy_c3", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    logic expWin;
    for (int i = 0; i < 8; i++) refMem[i] = initWord(i);

    // Reset held with both requests high
    setReq(0, 1'b0, 32'h04, 32'h0);
    setReq(1, 1'b0, 32'h10, 32'h0);
    step; step; step;
    checkOutput("rst_gnt_err", {28'b0, p1_gnt_o, p0_gnt_o, p1_err_o, p0_err_o}, 32'd0);
    checkOutput("rst_rvalid", {30'b0, p1_rvalid_o, p0_rvalid_o}, 32'd0);
    checkOutput("rst_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_p0_rdata", p0_rdata_o, 32'd0);
    checkOutput("rst_p1_rdata", p1_rdata_o, 32'd0);
    rst_i = 1'b1;
    p1_req_i = 1'b0;
    applyStimulus(0, 1'b0, 32'h04, 32'h0, 1'b0);

    // Port 0 write then read back
    applyStimulus(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b0, 32'h08, 32'h0, 1'b0);

    // Both ports reading continuously
    setReq(0, 1'b0, 32'h04, 32'h0);
    setReq(1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expWin = ~tbLast;
`else
      expWin = 1'b0;
`endif
      step;
      checkOutput("tie_gnt", {30'b0, p1_gnt_o, p0_gnt_o}, expWin ? 32'd2 : 32'd1);
      if (expWin) q1.push_back(refMem[4]);
      else        q0.push_back(refMem[1]);
      tbLast = expWin;
      step;
      step;
    end
    clearReqs();
    step;

    // Alignment and range checks on port 1
    applyStimulus(1, 1'b0, 32'h06, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 32'h1C, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 32'h03, 32'h12345678, 1'b1);

    // Reset asserted during the read-data cycle of a port 0 read
    setReq(0, 1'b0, 32'h08, 32'h0);
    step;
    checkOutput("rstmid_gnt", 32'(p0_gnt_o), 32'd1);
    clearReqs();
    step;
    checkOutput("rstmid_busy_rd", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    tbLast = 1'b1;
    #1;
    checkOutput("rstmid_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    checkOutput("rstmid_busy", 32'(busy_o), 32'd0);
    step;
    checkOutput("rstmid_rvalid", 32'(p0_rvalid_o), 32'd0);
    step;
    checkOutput("rstmid_rvalid2", 32'(p0_rvalid_o), 32'd0);
    rst_i = 1'b1;
    holdP0 = '0;
    step;
    checkOutput("rstmid_p0_rdata", p0_rdata_o, 32'd0);

    // Port 1 back-to-back writes, then read back through both ports
    applyStimulus(1, 1'b1, 32'h00, 32'h11111111, 1'b0);
    applyStimulus(1, 1'b1, 32'h04, 32'h22222222, 1'b0);
    applyStimulus(1, 1'b1, 32'h08, 32'h33333333, 1'b0);
    applyStimulus(0, 1'b0, 32'h00, 32'h0, 1'b0);
    step;
    applyStimulus(1, 1'b0, 32'h04, 32'h0, 1'b0);
    step;
    checkOutput("p0_rdata_hold", p0_rdata_o, holdP0);
    applyStimulus(1, 1'b0, 32'h08, 32'h0, 1'b0);

    step; step; step;
    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
